// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 2-flop sync, mid-bit sampling, 8N1 by default.
// Define UART_RX_PARITY_EN for an 8E1 frame with a parity check.
module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       framing_error,
  output logic       parity_error,
  output logic       overrun
);

  localparam int unsigned H = CLKS_PER_BIT >> 1;
  localparam logic [15:0] HALF_M1 = 16'(H - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic        sync_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        par_bad;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        pe_q, pe_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      sync_q    <= rx;
      rx_s_q    <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ack;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_M1) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q != (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s_q && !par_bad) begin
            // ack on the delivery edge is superseded by the new byte
            data_d  = shift_q;
            valid_d = 1'b1;
            ov_d    = valid_q & ~rx_ack;
            state_d = S_IDLE;
          end else if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            pe_d    = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            pe_d    = par_bad;
`endif
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    data          = data_q;
    valid         = valid_q;
    busy          = state_q != S_IDLE;
    framing_error = fe_q;
    overrun       = ov_q;
`ifdef UART_RX_PARITY_EN
    parity_error  = pe_q;
`else
    parity_error  = 1'b0;
`endif
  end

endmodule
